gpio_controller: RTL

GPIO_CONTROLLER -- requirements
Module: gpio_controller

---
 rtl/gpio_controller.sv | 97 +++++++++
 1 files changed

// File: rtl/gpio_controller.sv
// GPIO block: per-pin direction/output registers, two-flop input synchronizer,
// and rising/falling edge detection feeding a write-one-to-clear pending register.
module gpio_controller #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       a,
  input  logic             we,
  input  logic [31:0]      wd,
  output logic [31:0]      rd,
  output logic             irq,
  inout  wire  [WIDTH-1:0] gpioPorts
);

  localparam logic [2:0] A_DIR     = 3'd0;
  localparam logic [2:0] A_OUT     = 3'd1;
  localparam logic [2:0] A_IN      = 3'd2;
  localparam logic [2:0] A_RISE_EN = 3'd3;
  localparam logic [2:0] A_FALL_EN = 3'd4;
  localparam logic [2:0] A_PENDING = 3'd5;
  localparam logic [2:0] A_OUT_SET = 3'd6;
  localparam logic [2:0] A_OUT_CLR = 3'd7;

  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] event_set;
  logic [WIDTH-1:0] w1c;
  logic             unused_wd;

  assign wdata     = wd[WIDTH-1:0];
  assign unused_wd = ^wd;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    assign gpioPorts[i] = dir[i] ? out[i] : 1'bz;
  end

  assign rise      = sync2 & ~prev;
  assign fall      = ~sync2 & prev;
  assign event_set = (rise & rise_en) | (fall & fall_en);
  assign w1c       = (we && (a == A_PENDING)) ? wdata : '0;
  assign irq       = |pending;

  always_comb begin
    rd = '0;
    case (a)
      A_DIR:     rd[WIDTH-1:0] = dir;
      A_OUT:     rd[WIDTH-1:0] = out;
      A_IN:      rd[WIDTH-1:0] = sync2;
      A_RISE_EN: rd[WIDTH-1:0] = rise_en;
      A_FALL_EN: rd[WIDTH-1:0] = fall_en;
      A_PENDING: rd[WIDTH-1:0] = pending;
      default:   rd = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dir     <= '0;
      out     <= '0;
      rise_en <= '0;
      fall_en <= '0;
      pending <= '0;
      sync1   <= '0;
      sync2   <= '0;
      prev    <= '0;
    end else begin
      // pins are sampled whatever their direction, so outputs read back their own drive
      sync1 <= gpioPorts;
      sync2 <= sync1;
      prev  <= sync2;
      if (we) begin
        case (a)
          A_DIR:     dir     <= wdata;
          A_OUT:     out     <= wdata;
          A_RISE_EN: rise_en <= wdata;
          A_FALL_EN: fall_en <= wdata;
          A_OUT_SET: out     <= out | wdata;
          A_OUT_CLR: out     <= out & ~wdata;
          default:   ;
        endcase
      end
      // a new event on the same cycle as a clear keeps the bit set
      pending <= (pending & ~w1c) | event_set;
    end
  end

endmodule
